// File: rtl/mul_datapath.sv
// Shift-add multiplier datapath: multiplicand, multiplier and product registers,
// a carry flop, a step counter and the adder. It executes the strobes issued by
// the multiplier control FSM and returns the multiplier LSB and a step-complete flag.
module mul_datapath #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               areset_n,
  input  logic               load,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  input  logic               pd_shift,
  input  logic               pd_write,
  input  logic               mpr_shift,
  input  logic               alu_state,
  output logic               mpr_lsb,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mpr_q;
  logic [2*WIDTH-1:0] p_q;
  logic               c_q;
  logic [CW-1:0]      cnt_q;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [2*WIDTH-1:0] p_d;
  logic               c_d;
  logic               cnt_full;

  assign cnt_full = (cnt_q == CW'(WIDTH));

  // ALU: upper product half plus the multiplicand, or a straight pass-through.
  always_comb begin
    addend      = alu_state ? mcand_q : '0;
    {cout, sum} = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  end

  // Next product/carry from the pd_* strobes; a combined write+shift folds the
  // ALU carry straight into the MSB so no carry is lost.
  always_comb begin
    // NOTE: defaults first so every path assigns p_d/c_d and no latch is inferred.
    p_d = p_q;
    c_d = c_q;
    unique case ({pd_write, pd_shift})
      2'b10: begin
        p_d = {sum, p_q[WIDTH-1:0]};
        c_d = cout;
      end
      2'b01: begin
        p_d = {c_q, p_q[2*WIDTH-1:1]};
        c_d = 1'b0;
      end
      2'b11: begin
        p_d = {cout, sum, p_q[WIDTH-1:1]};
        c_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Operand capture and product/carry update; load overrides every strobe.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      mcand_q <= '0;
      p_q     <= '0;
      c_q     <= 1'b0;
    end else if (load) begin
      mcand_q <= mcand_in;
      p_q     <= '0;
      c_q     <= 1'b0;
    end else begin
      p_q     <= p_d;
      c_q     <= c_d;
    end
  end

  // Multiplier shift and step count; both freeze once WIDTH steps have been taken.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      mpr_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      mpr_q <= mplier_in;
      cnt_q <= '0;
    end else if (mpr_shift && !cnt_full) begin
      mpr_q <= {1'b0, mpr_q[WIDTH-1:1]};
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign mpr_lsb = mpr_q[0];
  assign done    = cnt_full;
  assign product = p_q;

endmodule
